// File: rtl/branch_resolver.sv
// Execute-side branch resolver: queues fetch-time predictions, checks them against
// real outcomes, and issues flush/redirect, BHT training writes and perf counters.
module branch_resolver #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_valid_i,
   output logic             fetch_ready_o,
   input  logic [31:0]      fetch_pc_i,
   input  logic             fetch_pred_taken_i,
   input  logic [31:0]      fetch_pred_tgt_i,
   input  logic             ex_valid_i,
   input  logic             ex_is_branch_i,
   input  logic             ex_taken_i,
   input  logic [31:0]      ex_target_i,
   output logic             flush_o,
   output logic [31:0]      redirect_pc_o,
   output logic             upd_valid_o,
   output logic [31:0]      upd_pc_o,
   output logic             upd_taken_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o,
   output logic             err_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] QUEUE_FULL = (PTR_W + 1)'(DEPTH);

   logic [31:0]      q_pc  [DEPTH];
   logic             q_pt  [DEPTH];
   logic [31:0]      q_tgt [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   logic             full;
   logic             empty;
   logic             pop;
   logic             push;
   logic             pop_err;
   logic             push_err;
   logic             mispredict;
   logic [31:0]      head_pc;
   logic             head_pt;
   logic [31:0]      head_tgt;
   logic [31:0]      correct_pc;

   assign full          = (count == QUEUE_FULL);
   assign empty         = (count == '0);
   assign fetch_ready_o = ~full;

   assign head_pc  = q_pc[rd_ptr];
   assign head_pt  = q_pt[rd_ptr];
   assign head_tgt = q_tgt[rd_ptr];

   // A pop that frees a slot makes room for a same-cycle push even when full;
   // everything is squashed while the flush pulse is out.
   always_comb begin
      pop        = ex_valid_i & ~flush_o & ~empty;
      push       = fetch_valid_i & ~flush_o & (~full | pop);
      pop_err    = ex_valid_i & ~flush_o & empty;
      push_err   = fetch_valid_i & ~flush_o & full & ~pop;
      mispredict = 1'b0;
      correct_pc = head_pc + 32'd4;
      if (pop) begin
         if (ex_is_branch_i)
            mispredict = (head_pt != ex_taken_i) |
                         (ex_taken_i & (head_tgt != ex_target_i));
         else
            mispredict = head_pt;
      end
      if (ex_is_branch_i & ex_taken_i)
         correct_pc = ex_target_i;
   end

   // Storage needs no reset: the pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      if (push & ~mispredict) begin
         q_pc[wr_ptr]  <= fetch_pc_i;
         q_pt[wr_ptr]  <= fetch_pred_taken_i;
         q_tgt[wr_ptr] <= fetch_pred_tgt_i;
      end
   end

   // A mispredict discards the whole queue, including any wrong-path push this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (mispredict) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push & ~pop)
            count <= count + 1'b1;
         else if (pop & ~push)
            count <= count - 1'b1;
      end
   end

   // Resolution results appear one cycle after the pop edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_o       <= 1'b0;
         redirect_pc_o <= '0;
         upd_valid_o   <= 1'b0;
         upd_pc_o      <= '0;
         upd_taken_o   <= 1'b0;
         branch_cnt_o  <= '0;
         mispred_cnt_o <= '0;
         err_o         <= 1'b0;
      end else begin
         flush_o     <= mispredict;
         upd_valid_o <= pop & ex_is_branch_i;
         if (mispredict)
            redirect_pc_o <= correct_pc;
         if (pop) begin
            upd_pc_o    <= head_pc;
            upd_taken_o <= ex_taken_i;
         end
         if (pop & ex_is_branch_i & ~(&branch_cnt_o))
            branch_cnt_o <= branch_cnt_o + CNT_W'(1);
         if (mispredict & ~(&mispred_cnt_o))
            mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
         if (pop_err | push_err)
            err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver (CNT_W=4 build so counter saturation is reachable).
module tb_branch_resolver;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             fetch_valid_i = 1'b0;
   logic             fetch_ready_o;
   logic [31:0]      fetch_pc_i = '0;
   logic             fetch_pred_taken_i = 1'b0;
   logic [31:0]      fetch_pred_tgt_i = '0;
   logic             ex_valid_i = 1'b0;
   logic             ex_is_branch_i = 1'b0;
   logic             ex_taken_i = 1'b0;
   logic [31:0]      ex_target_i = '0;
   logic             flush_o;
   logic [31:0]      redirect_pc_o;
   logic             upd_valid_o;
   logic [31:0]      upd_pc_o;
   logic             upd_taken_o;
   logic [CNT_W-1:0] branch_cnt_o;
   logic [CNT_W-1:0] mispred_cnt_o;
   logic             err_o;

   int tests_run    = 0;
   int tests_failed = 0;

   branch_resolver #(.DEPTH(4), .CNT_W(CNT_W)) dut (
      .clk                (clk),
      .rst                (rst),
      .fetch_valid_i      (fetch_valid_i),
      .fetch_ready_o      (fetch_ready_o),
      .fetch_pc_i         (fetch_pc_i),
      .fetch_pred_taken_i (fetch_pred_taken_i),
      .fetch_pred_tgt_i   (fetch_pred_tgt_i),
      .ex_valid_i         (ex_valid_i),
      .ex_is_branch_i     (ex_is_branch_i),
      .ex_taken_i         (ex_taken_i),
      .ex_target_i        (ex_target_i),
      .flush_o            (flush_o),
      .redirect_pc_o      (redirect_pc_o),
      .upd_valid_o        (upd_valid_o),
      .upd_pc_o           (upd_pc_o),
      .upd_taken_o        (upd_taken_o),
      .branch_cnt_o       (branch_cnt_o),
      .mispred_cnt_o      (mispred_cnt_o),
      .err_o              (err_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fetch_valid_i = 1'b0;
      ex_valid_i = 1'b0;
      #12;
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic set_push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
      fetch_valid_i      = 1'b1;
      fetch_pc_i         = pc;
      fetch_pred_taken_i = pt;
      fetch_pred_tgt_i   = tgt;
   endtask

   task automatic set_pop(input logic br, input logic tk, input logic [31:0] tgt);
      ex_valid_i     = 1'b1;
      ex_is_branch_i = br;
      ex_taken_i     = tk;
      ex_target_i    = tgt;
   endtask

   task automatic applyStimulus();
      tick();
      fetch_valid_i = 1'b0;
      ex_valid_i    = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++; if (fetch_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready got %b exp 1", fetch_ready_o); end
      tests_run++; if (flush_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flush got %b exp 0", flush_o); end
      tests_run++; if (upd_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_upd_valid got %b exp 0", upd_valid_o); end
      tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %b exp 0", err_o); end
      tests_run++; if (redirect_pc_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_redirect got %h exp 0", redirect_pc_o); end
      tests_run++; if ({branch_cnt_o, mispred_cnt_o} !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_counters got %h/%h exp 0/0", branch_cnt_o, mispred_cnt_o); end
   endtask

   task automatic test_correct_not_taken();
      do_reset();
      set_push(32'h100, 1'b0, 32'h0); applyStimulus();
      set_pop(1'b1, 1'b0, 32'h0); applyStimulus();
      tests_run++; if (upd_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL nt_upd_valid got %b exp 1", upd_valid_o); end
      tests_run++; if (upd_pc_o !== 32'h100) begin tests_failed++; $display("[TB] FAIL nt_upd_pc got %h exp 100", upd_pc_o); end
      tests_run++; if (upd_taken_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL nt_upd_taken got %b exp 0", upd_taken_o); end
      tests_run++; if (flush_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL nt_flush got %b exp 0", flush_o); end
      tests_run++; if (branch_cnt_o !== 4'd1) begin tests_failed++; $display("[TB] FAIL nt_branch_cnt got %0d exp 1", branch_cnt_o); end
      tests_run++; if (mispred_cnt_o !== 4'd0) begin tests_failed++; $display("[TB] FAIL nt_mispred_cnt got %0d exp 0", mispred_cnt_o); end
      applyStimulus();
      tests_run++; if (upd_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL nt_upd_pulse got %b exp 0", upd_valid_o); end
   endtask

   task automatic test_mispredict_taken();
      do_reset();
      set_push(32'h200, 1'b0, 32'h0); applyStimulus();
      set_push(32'h204, 1'b0, 32'h0); applyStimulus();
      set_pop(1'b1, 1'b1, 32'h240); applyStimulus();
      tests_run++; if (flush_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL mp_flush got %b exp 1", flush_o); end
      tests_run++; if (redirect_pc_o !== 32'h240) begin tests_failed++; $display("[TB] FAIL mp_redirect got %h exp 240", redirect_pc_o); end
      tests_run++; if (mispred_cnt_o !== 4'd1) begin tests_failed++; $display("[TB] FAIL mp_mispred_cnt got %0d exp 1", mispred_cnt_o); end
      tests_run++; if ({upd_valid_o, upd_taken_o} !== 2'b11) begin tests_failed++; $display("[TB] FAIL mp_upd got %b exp 11", {upd_valid_o, upd_taken_o}); end
      applyStimulus();
      tests_run++; if (flush_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL mp_flush_pulse got %b exp 0", flush_o); end
      tests_run++; if (redirect_pc_o !== 32'h240) begin tests_failed++; $display("[TB] FAIL mp_redirect_hold got %h exp 240", redirect_pc_o); end
      // Queue was cleared: three pushes must leave room for one more.
      for (int i = 0; i < 3; i++) begin
         set_push(32'h300 + 32'(4 * i), 1'b0, 32'h0); applyStimulus();
      end
      tests_run++; if (fetch_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL mp_queue_cleared ready got %b exp 1", fetch_ready_o); end
   endtask

   task automatic test_target_and_alias();
      do_reset();
      set_push(32'h280, 1'b1, 32'h300); applyStimulus();
      set_pop(1'b1, 1'b1, 32'h310); applyStimulus();
      tests_run++; if (flush_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL tgt_flush got %b exp 1", flush_o); end
      tests_run++; if (redirect_pc_o !== 32'h310) begin tests_failed++; $display("[TB] FAIL tgt_redirect got %h exp 310", redirect_pc_o); end
      applyStimulus();
      set_push(32'h400, 1'b1, 32'h500); applyStimulus();
      set_pop(1'b0, 1'b0, 32'h0); applyStimulus();
      tests_run++; if (flush_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL alias_flush got %b exp 1", flush_o); end
      tests_run++; if (redirect_pc_o !== 32'h404) begin tests_failed++; $display("[TB] FAIL alias_redirect got %h exp 404", redirect_pc_o); end
      tests_run++; if (upd_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL alias_upd_valid got %b exp 0", upd_valid_o); end
      tests_run++; if (mispred_cnt_o !== 4'd2) begin tests_failed++; $display("[TB] FAIL alias_mispred_cnt got %0d exp 2", mispred_cnt_o); end
      tests_run++; if (branch_cnt_o !== 4'd1) begin tests_failed++; $display("[TB] FAIL alias_branch_cnt got %0d exp 1", branch_cnt_o); end
      applyStimulus();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_pc [4];
      exp_pc[0] = 32'h14; exp_pc[1] = 32'h18; exp_pc[2] = 32'h1C; exp_pc[3] = 32'h20;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_push(32'h10 + 32'(4 * i), 1'b0, 32'h0); applyStimulus();
      end
      tests_run++; if (fetch_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_ready got %b exp 0", fetch_ready_o); end
      set_push(32'h20, 1'b0, 32'h0); set_pop(1'b1, 1'b0, 32'h0); applyStimulus();
      tests_run++; if (upd_pc_o !== 32'h10) begin tests_failed++; $display("[TB] FAIL pushpop_upd_pc got %h exp 10", upd_pc_o); end
      tests_run++; if ({fetch_ready_o, err_o} !== 2'b00) begin tests_failed++; $display("[TB] FAIL pushpop_ready_err got %b exp 00", {fetch_ready_o, err_o}); end
      set_push(32'h24, 1'b0, 32'h0); applyStimulus();
      tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow_err got %b exp 1", err_o); end
      for (int i = 0; i < 4; i++) begin
         set_pop(1'b1, 1'b0, 32'h0); applyStimulus();
         tests_run++; if (upd_pc_o !== exp_pc[i]) begin tests_failed++; $display("[TB] FAIL drain_pc%0d got %h exp %h", i, upd_pc_o, exp_pc[i]); end
      end
      tests_run++; if (fetch_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL drained_ready got %b exp 1", fetch_ready_o); end
      tests_run++; if (branch_cnt_o !== 4'd5) begin tests_failed++; $display("[TB] FAIL drained_branch_cnt got %0d exp 5", branch_cnt_o); end
   endtask

   task automatic test_squash_and_empty();
      do_reset();
      set_push(32'h600, 1'b0, 32'h0); applyStimulus();
      set_pop(1'b1, 1'b1, 32'h700); set_push(32'h604, 1'b0, 32'h0); applyStimulus();
      tests_run++; if (flush_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL sq_flush got %b exp 1", flush_o); end
      tests_run++; if (redirect_pc_o !== 32'h700) begin tests_failed++; $display("[TB] FAIL sq_redirect got %h exp 700", redirect_pc_o); end
      set_pop(1'b1, 1'b0, 32'h0); set_push(32'h800, 1'b0, 32'h0); applyStimulus();
      tests_run++; if ({flush_o, upd_valid_o, err_o} !== 3'b000) begin tests_failed++; $display("[TB] FAIL sq_ignored got %b exp 000", {flush_o, upd_valid_o, err_o}); end
      set_pop(1'b1, 1'b1, 32'h900); applyStimulus();
      tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL empty_pop_err got %b exp 1", err_o); end
      tests_run++; if ({flush_o, upd_valid_o} !== 2'b00) begin tests_failed++; $display("[TB] FAIL empty_pop_outputs got %b exp 00", {flush_o, upd_valid_o}); end
      tests_run++; if (branch_cnt_o !== 4'd1) begin tests_failed++; $display("[TB] FAIL empty_pop_branch_cnt got %0d exp 1", branch_cnt_o); end
      applyStimulus();
      tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_sticky got %b exp 1", err_o); end
   endtask

   task automatic test_saturation_and_reset();
      do_reset();
      for (int i = 0; i < 15; i++) begin
         set_push(32'h1000, 1'b0, 32'h0); applyStimulus();
         set_pop(1'b1, 1'b1, 32'h2000); applyStimulus();
         applyStimulus();
      end
      tests_run++; if (mispred_cnt_o !== 4'hF) begin tests_failed++; $display("[TB] FAIL sat_reach got %h exp f", mispred_cnt_o); end
      set_push(32'h1000, 1'b0, 32'h0); applyStimulus();
      set_pop(1'b1, 1'b1, 32'h2000); applyStimulus();
      tests_run++; if (mispred_cnt_o !== 4'hF) begin tests_failed++; $display("[TB] FAIL sat_mispred got %h exp f", mispred_cnt_o); end
      tests_run++; if (branch_cnt_o !== 4'hF) begin tests_failed++; $display("[TB] FAIL sat_branch got %h exp f", branch_cnt_o); end
      tests_run++; if (flush_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL sat_flush got %b exp 1", flush_o); end
      #2 rst = 1'b1;
      #1;
      tests_run++; if (flush_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_rst_flush got %b exp 0", flush_o); end
      tests_run++; if ({branch_cnt_o, mispred_cnt_o} !== 8'h00) begin tests_failed++; $display("[TB] FAIL async_rst_counters got %h/%h exp 0/0", branch_cnt_o, mispred_cnt_o); end
      tests_run++; if (redirect_pc_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL async_rst_redirect got %h exp 0", redirect_pc_o); end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_correct_not_taken();
      test_mispredict_taken();
      test_target_and_alias();
      test_back_to_back();
      test_squash_and_empty();
      test_saturation_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
